// File: rtl/ram_5x32.sv
// Single-port synchronous RAM, 2**ADDRESS_WIDTH x DATA_WIDTH.
//   clk_i      : clock
//   we_i       : write enable, commits data_i to address_i at the rising edge
//   address_i  : read/write address
//   data_i     : write data
//   data_o     : registered read data for the address presented the previous cycle
// Contents are not reset; the controller never exposes a word it did not write.
module ram_5x32 #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MEMORY_DEPTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o
);

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[address_i] <= data_i;
        end
        data_o <= mem[address_i];
    end

endmodule

// File: rtl/ram_fifo_out_stage.sv
// One-word output register of the RAM FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush (drops held word and any arriving read data)
//   out_ready_i   : consumer ready
//   rd_pending_i  : RAM read data for the head word arrives this cycle
//   ram_rdata_i   : RAM read data
//   bypass_i      : push goes straight into the register (RAM empty, nothing in flight)
//   in_data_i     : push word used on bypass
//   slot_free_o   : register can accept a word at the next edge
//   out_valid_o   : head word valid
//   out_data_o    : head word
module ram_fifo_out_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  out_ready_i,
    input  logic                  rd_pending_i,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  bypass_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  slot_free_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    always_comb begin
        slot_free_o = !out_valid || out_ready_i;
    end

    // rd_pending and bypass are never both set: bypass requires nothing in flight.
    // A fetch is only issued when the slot is free, so arriving RAM data never
    // overwrites an unpopped word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear_i) begin
            out_valid <= 1'b0;
        end else if (rd_pending_i) begin
            out_valid <= 1'b1;
            out_data  <= ram_rdata_i;
        end else if (bypass_i) begin
            out_valid <= 1'b1;
            out_data  <= in_data_i;
        end else if (out_valid && out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    assign out_valid_o = out_valid;
    assign out_data_o  = out_data;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller driving the single port of ram_5x32.
//   clk_i, rst_ni        : clock (shared with the RAM), asynchronous active-low reset
//   clear_i              : synchronous flush
//   in_valid_i/in_ready_o/in_data_i    : push side
//   out_valid_o/out_ready_i/out_data_o : pop side (registered head word, first-word fall-through)
//   level_o              : words held (RAM + in-flight read + output register)
//   ram_we_o/ram_addr_o/ram_wdata_o    : RAM port drive
//   ram_rdata_i          : RAM read data, valid the cycle after the read address
// The RAM port serves either one read prefetch or one push per cycle; prefetch wins.
module ram_fifo_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MEMORY_DEPTH  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [DATA_WIDTH-1:0]    in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic [ADDRESS_WIDTH:0]   level_o,
    output logic                     ram_we_o,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0]    ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]    ram_rdata_i
);

    localparam logic [ADDRESS_WIDTH:0]   DEPTH_L = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = ADDRESS_WIDTH'(1);

    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [ADDRESS_WIDTH:0]   ram_count;
    logic                     rd_pending;

    logic slot_free;
    logic out_valid;
    logic fetch;
    logic bypass;
    logic ready;
    logic push_ram;

    always_comb begin
        fetch    = (ram_count != '0) && !rd_pending && slot_free && !clear_i;
        // Bypass only when nothing older exists in RAM or in flight, so order holds.
        bypass   = (ram_count == '0) && !rd_pending && slot_free && in_valid_i && !clear_i;
        ready    = (ram_count < DEPTH_L) && !fetch && !clear_i;
        push_ram = in_valid_i && ready && !bypass;
    end

    always_comb begin
        ram_we_o    = push_ram;
        ram_addr_o  = push_ram ? wr_ptr : rd_ptr;
        ram_wdata_o = in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_count  <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fetch;
            if (fetch) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                ram_count <= ram_count - CNT_ONE;
            end else if (push_ram) begin
                wr_ptr    <= wr_ptr + PTR_ONE;
                ram_count <= ram_count + CNT_ONE;
            end
        end
    end

    ram_fifo_out_stage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_stage (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .out_ready_i  (out_ready_i),
        .rd_pending_i (rd_pending),
        .ram_rdata_i  (ram_rdata_i),
        .bypass_i     (bypass),
        .in_data_i    (in_data_i),
        .slot_free_o  (slot_free),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data_o)
    );

    assign out_valid_o = out_valid;
    assign in_ready_o  = ready;
    assign level_o     = ram_count
                       + (ADDRESS_WIDTH+1)'(rd_pending)
                       + (ADDRESS_WIDTH+1)'(out_valid);

endmodule
